// File: rtl/audio_dac_feeder.sv
// Avalon-MM fed stereo FIFO that serialises samples to a WM8731 DAC in I2S slave mode.
// BCLK and DACLRCK come from the codec and are synchronised into the clk domain before use.
module audio_dac_feeder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        aud_bclk,
    input  logic        aud_daclrck,
    output logic        aud_dacdat,
    output logic [1:0]  f_data_req
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(SAMPLE_W + 1);
    localparam int ENT_W = 2 * SAMPLE_W;

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             enable;
    logic             overflow;
    logic             underrun;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                   bclk_last;
    logic                   lrck_last;
    logic                   bclk_fall;
    logic                   lrck_fall;
    logic                   lrck_rise;

    logic signed [SAMPLE_W-1:0] shift_reg;
    logic signed [SAMPLE_W-1:0] hold_reg;
    logic [BC_W-1:0]            bit_cnt;

    logic             wr_en;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       count_nib;
    logic [ENT_W-1:0] head;

    assign wr_en      = chipselect & ~write_n;
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = wr_en & (address == 2'd0);
    assign pop        = lrck_fall & enable & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push       = push_req & (~fifo_full | pop);
    assign head       = fifo_mem[rd_ptr];
    assign f_data_req = {(count <= CNT_W'(FIFO_DEPTH / 2)), ~fifo_full};
    assign count_nib  = 4'(count);

    assign bclk_fall = bclk_last & ~bclk_sync[SYNC_STAGES-1];
    assign lrck_fall = lrck_last & ~lrck_sync[SYNC_STAGES-1];
    assign lrck_rise = ~lrck_last & lrck_sync[SYNC_STAGES-1];

    // Codec clock synchronisers and edge history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_last <= 1'b0;
            lrck_last <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], aud_daclrck};
            bclk_last <= bclk_sync[SYNC_STAGES-1];
            lrck_last <= lrck_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= writedata[ENT_W-1:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Control and sticky status; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_en && address == 2'd1) begin
                enable <= writedata[0];
                if (writedata[1]) begin
                    underrun <= 1'b0;
                end
                if (writedata[2]) begin
                    overflow <= 1'b0;
                end
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
            if (lrck_fall && enable && fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd1:    readdata <= {31'b0, enable};
                2'd2:    readdata <= {24'b0, count_nib, overflow, underrun, f_data_req};
                default: readdata <= '0;
            endcase
        end
    end

    // Slot loads take priority over a coincident BCLK falling edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg  <= '0;
            hold_reg   <= '0;
            bit_cnt    <= '0;
            aud_dacdat <= 1'b0;
        end else if (lrck_fall) begin
            if (pop) begin
                shift_reg <= head[ENT_W-1:SAMPLE_W];
                hold_reg  <= head[SAMPLE_W-1:0];
            end else begin
                shift_reg <= '0;
                hold_reg  <= '0;
            end
            bit_cnt <= BC_W'(SAMPLE_W);
        end else if (lrck_rise) begin
            shift_reg <= hold_reg;
            bit_cnt   <= BC_W'(SAMPLE_W);
        end else if (bclk_fall) begin
            if (bit_cnt != '0) begin
                aud_dacdat <= shift_reg[SAMPLE_W-1];
                shift_reg  <= shift_reg << 1;
                bit_cnt    <= bit_cnt - BC_W'(1);
            end else begin
                aud_dacdat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_feeder.sv
// Directed bench for audio_dac_feeder: Avalon register access plus I2S serial output
// with BCLK = clk/8 and a 16-BCLK slot per channel.
module tb_audio_dac_feeder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        aud_bclk = 1'b0;
    logic        aud_daclrck = 1'b1;
    logic        aud_dacdat;
    logic [1:0]  f_data_req;

    int checks = 0;
    int errors = 0;

    audio_dac_feeder #(
        .FIFO_DEPTH(4),
        .SAMPLE_W(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .chipselect(chipselect),
        .write_n(write_n),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .aud_bclk(aud_bclk),
        .aud_daclrck(aud_daclrck),
        .aud_dacdat(aud_dacdat),
        .f_data_req(f_data_req)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic half_bclk();
        repeat (4) @(negedge clk);
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    // LRCK changes with a BCLK rising edge; 16 falling edges follow, each sampled
    // just before the next rising edge. Optional push lands on the pop clock.
    task automatic run_slot(input logic lr, input logic do_push, input logic [31:0] pdata,
                            output logic [15:0] bits);
        half_bclk();
        aud_bclk    = 1'b1;
        aud_daclrck = lr;
        if (do_push) begin
            repeat (2) @(negedge clk);
            chipselect = 1'b1;
            write_n    = 1'b0;
            address    = 2'd0;
            writedata  = pdata;
            @(negedge clk);
            chipselect = 1'b0;
            write_n    = 1'b1;
            @(negedge clk);
        end else begin
            half_bclk();
        end
        for (int k = 15; k >= 0; k--) begin
            aud_bclk = 1'b0;
            half_bclk();
            bits[k] = aud_dacdat;
            if (k != 0) begin
                aud_bclk = 1'b1;
                half_bclk();
            end
        end
    endtask

    task automatic run_frame(input logic do_push, input logic [31:0] pdata,
                             output logic [31:0] fr);
        logic [15:0] l;
        logic [15:0] r;
        run_slot(1'b0, do_push, pdata, l);
        run_slot(1'b1, 1'b0, 32'd0, r);
        fr = {l, r};
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (aud_dacdat !== 1'b0) begin
            errors++; $display("FAIL reset_dacdat: got %b expected 0", aud_dacdat);
        end
        checks++;
        if (f_data_req !== 2'b11) begin
            errors++; $display("FAIL reset_fdr: got %b expected 11", f_data_req);
        end
        checks++;
        if (readdata !== 32'd0) begin
            errors++; $display("FAIL reset_readdata: got %h expected 00000000", readdata);
        end
        reset_n = 1'b1;
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin
            errors++; $display("FAIL reset_status: got %h expected 00000003", rd);
        end
        av_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        logic [31:0] fr;
        av_write(2'd0, 32'hA5A5_0F0F);
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0013) begin
            errors++; $display("FAIL single_status_count1: got %h expected 00000013", rd);
        end
        av_write(2'd1, 32'h1);
        av_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++; $display("FAIL single_enable: got %h expected 00000001", rd);
        end
        run_frame(1'b0, 32'd0, fr);
        checks++;
        if (fr[31:16] !== 16'hA5A5) begin
            errors++; $display("FAIL single_left: got %h expected a5a5", fr[31:16]);
        end
        checks++;
        if (fr[15:0] !== 16'h0F0F) begin
            errors++; $display("FAIL single_right: got %h expected 0f0f", fr[15:0]);
        end
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin
            errors++; $display("FAIL single_status_empty: got %h expected 00000003", rd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [31:0] fr;
        logic [31:0] w [4];
        logic [1:0]  fdr_exp [4];
        w[0] = 32'h1234_5678; w[1] = 32'h9ABC_DEF0;
        w[2] = 32'h0001_8000; w[3] = 32'hFFFF_7FFE;
        fdr_exp[0] = 2'b11; fdr_exp[1] = 2'b11; fdr_exp[2] = 2'b01; fdr_exp[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            av_write(2'd0, w[i]);
            checks++;
            if (f_data_req !== fdr_exp[i]) begin
                errors++; $display("FAIL ovf_fdr_push%0d: got %b expected %b", i + 1, f_data_req, fdr_exp[i]);
            end
        end
        av_write(2'd0, 32'hDEAD_BEEF);
        checks++;
        if (f_data_req !== 2'b00) begin
            errors++; $display("FAIL ovf_fdr_drop: got %b expected 00", f_data_req);
        end
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0048) begin
            errors++; $display("FAIL ovf_status_set: got %h expected 00000048", rd);
        end
        av_write(2'd1, 32'h5);
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0040) begin
            errors++; $display("FAIL ovf_status_clr: got %h expected 00000040", rd);
        end
        av_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++; $display("FAIL ovf_enable_kept: got %h expected 00000001", rd);
        end
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b0, 32'd0, fr);
            checks++;
            if (fr !== w[i]) begin
                errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, fr, w[i]);
            end
        end
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin
            errors++; $display("FAIL ovf_status_empty: got %h expected 00000003", rd);
        end
    endtask

    task automatic test_push_on_pop();
        logic [31:0] rd;
        logic [31:0] fr;
        logic [31:0] w [5];
        w[0] = 32'h0102_0304; w[1] = 32'h1111_2222; w[2] = 32'h3333_4444;
        w[3] = 32'h5555_6666; w[4] = 32'h7777_8888;
        for (int i = 0; i < 4; i++) begin
            av_write(2'd0, w[i]);
        end
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0040) begin
            errors++; $display("FAIL pop_status_full: got %h expected 00000040", rd);
        end
        run_frame(1'b1, w[4], fr);
        checks++;
        if (fr !== w[0]) begin
            errors++; $display("FAIL pop_frame0: got %h expected %h", fr, w[0]);
        end
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0040) begin
            errors++; $display("FAIL pop_status_after: got %h expected 00000040", rd);
        end
        for (int i = 1; i < 5; i++) begin
            run_frame(1'b0, 32'd0, fr);
            checks++;
            if (fr !== w[i]) begin
                errors++; $display("FAIL pop_frame%0d: got %h expected %h", i, fr, w[i]);
            end
        end
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin
            errors++; $display("FAIL pop_status_empty: got %h expected 00000003", rd);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] rd;
        logic [31:0] fr;
        run_frame(1'b0, 32'd0, fr);
        checks++;
        if (fr !== 32'd0) begin
            errors++; $display("FAIL urun_frame: got %h expected 00000000", fr);
        end
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0007) begin
            errors++; $display("FAIL urun_status_set: got %h expected 00000007", rd);
        end
        av_write(2'd1, 32'h3);
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin
            errors++; $display("FAIL urun_status_clr: got %h expected 00000003", rd);
        end
        av_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++; $display("FAIL urun_enable_kept: got %h expected 00000001", rd);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        logic [31:0] fr;
        logic [15:0] r;
        av_write(2'd0, 32'hC3C3_5A5A);
        av_write(2'd0, 32'h1111_2222);
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0023) begin
            errors++; $display("FAIL mid_status_pre: got %h expected 00000023", rd);
        end
        half_bclk();
        aud_bclk    = 1'b1;
        aud_daclrck = 1'b0;
        half_bclk();
        aud_bclk = 1'b0;
        half_bclk();
        checks++;
        if (aud_dacdat !== 1'b1) begin
            errors++; $display("FAIL mid_first_bit: got %b expected 1", aud_dacdat);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (aud_dacdat !== 1'b0) begin
            errors++; $display("FAIL mid_reset_dacdat: got %b expected 0", aud_dacdat);
        end
        @(negedge clk);
        reset_n = 1'b1;
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin
            errors++; $display("FAIL mid_status_post: got %h expected 00000003", rd);
        end
        av_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_0000) begin
            errors++; $display("FAIL mid_enable_post: got %h expected 00000000", rd);
        end
        av_write(2'd0, 32'h8001_7FFF);
        av_write(2'd1, 32'h1);
        run_slot(1'b1, 1'b0, 32'd0, r);
        checks++;
        if (r !== 16'h0000) begin
            errors++; $display("FAIL mid_right_idle: got %h expected 0000", r);
        end
        run_frame(1'b0, 32'd0, fr);
        checks++;
        if (fr !== 32'h8001_7FFF) begin
            errors++; $display("FAIL mid_resume_frame: got %h expected 80017fff", fr);
        end
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin
            errors++; $display("FAIL mid_status_end: got %h expected 00000003", rd);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_push_on_pop();
        test_underrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
